// File: rtl/hex8_scan_decoder.sv
// hex8_scan_decoder
// Passive receiver for an 8-digit multiplexed seven-segment bus. SEL/SEG are
// sampled every cycle. Each digit must settle before it is decoded back to a
// hex nibble, and the nibbles are reassembled into the 32-bit value the LEDs show.
//
// Ports:
//   Clk          system clock, rising edge
//   Reset_n      asynchronous active-low reset
//   SEL[7:0]     one-hot digit select, bit i drives nibble Disp_Data[4i+3:4i]
//   SEG[7:0]     active-low segments {dp,g,f,e,d,c,b,a}
//   Disp_Data    last complete frame
//   Frame_Valid  one-cycle pulse when Disp_Data updates
//   Digit_Mask   digits captured so far in the current partial frame
//   Seg_Err      one-cycle pulse, undecodable segment pattern on a one-hot digit
//   Sel_Err      one-cycle pulse, multi-hot SEL
//   Scan_Lost    level, no valid capture for TIMEOUT_CYCLES cycles
module hex8_scan_decoder #(
  parameter int CLOCK_FREQ     = 50_000_000,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 500_000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [7:0]  SEL,
  input  logic [7:0]  SEG,
  output logic [31:0] Disp_Data,
  output logic        Frame_Valid,
  output logic [7:0]  Digit_Mask,
  output logic        Seg_Err,
  output logic        Sel_Err,
  output logic        Scan_Lost
);

  // CLOCK_FREQ is informational only; it contributes nothing to the width.
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1) + ((CLOCK_FREQ > 0) ? 0 : 0);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_WAIT, S_DECODE, S_HOLD} state_t;

  state_t            r_state, w_nextState;
  logic [CNT_W-1:0]  r_cnt, w_cntNext;
  logic [TO_W-1:0]   r_toCnt;
  logic [7:0]        r_selQ, r_segQ, r_selD, r_segD;
  logic [31:0]       r_shadow;

  logic              w_change;
  logic              w_doDecode;
  logic              w_selBlank, w_selOneHot;
  logic [4:0]        w_dec;
  logic              w_capture, w_segErr, w_selErr, w_frameDone;
  logic [7:0]        w_maskNew;
  logic [31:0]       w_shadowNew;

  // Returns {valid, nibble}. Every legal glyph has DP off (bit7 high).
  function automatic logic [4:0] segToNibble(input logic [7:0] seg);
    logic [4:0] res;
    res = 5'h00;
    case (seg)
      8'hC0: res = {1'b1, 4'h0};
      8'hF9: res = {1'b1, 4'h1};
      8'hA4: res = {1'b1, 4'h2};
      8'hB0: res = {1'b1, 4'h3};
      8'h99: res = {1'b1, 4'h4};
      8'h92: res = {1'b1, 4'h5};
      8'h82: res = {1'b1, 4'h6};
      8'hF8: res = {1'b1, 4'h7};
      8'h80: res = {1'b1, 4'h8};
      8'h90: res = {1'b1, 4'h9};
      8'h88: res = {1'b1, 4'hA};
      8'h83: res = {1'b1, 4'hB};
      8'hC6: res = {1'b1, 4'hC};
      8'hA1: res = {1'b1, 4'hD};
      8'h86: res = {1'b1, 4'hE};
      8'h8E: res = {1'b1, 4'hF};
      default: res = 5'h00;
    endcase
    return res;
  endfunction

  // Two-stage sampling; change compares the newest sample with the one before.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_selQ <= 8'h00;
      r_segQ <= 8'h00;
      r_selD <= 8'h00;
      r_segD <= 8'h00;
    end else begin
      r_selQ <= SEL;
      r_segQ <= SEG;
      r_selD <= r_selQ;
      r_segD <= r_segQ;
    end
  end

  assign w_change = {r_selQ, r_segQ} != {r_selD, r_segD};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_WAIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_cntNext;
    end
  end

  // A change seen in S_DECODE means the sample being decoded differs from the
  // settled one, so settling restarts instead of decoding a one-sample glitch.
  always_comb begin
    w_nextState = r_state;
    w_cntNext   = r_cnt;
    w_doDecode  = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (w_change) begin
          w_cntNext = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_nextState = S_DECODE;
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end
      S_DECODE: begin
        if (w_change) begin
          w_nextState = S_WAIT;
          w_cntNext   = '0;
        end else begin
          w_doDecode  = 1'b1;
          w_nextState = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_change) begin
          w_nextState = S_WAIT;
          w_cntNext   = '0;
        end
      end
      default: begin
        w_nextState = S_WAIT;
        w_cntNext   = '0;
      end
    endcase
  end

  assign w_selBlank  = (r_selQ == 8'h00);
  assign w_selOneHot = $onehot(r_selQ);
  assign w_dec       = segToNibble(r_segQ);

  assign w_selErr    = w_doDecode && !w_selBlank && !w_selOneHot;
  assign w_segErr    = w_doDecode && w_selOneHot && !w_dec[4];
  assign w_capture   = w_doDecode && w_selOneHot && w_dec[4];
  assign w_maskNew   = Digit_Mask | r_selQ;
  assign w_frameDone = w_capture && (w_maskNew == 8'hFF);

  always_comb begin
    w_shadowNew = r_shadow;
    for (int i = 0; i < 8; i++) begin
      if (r_selQ[i]) begin
        w_shadowNew[4*i +: 4] = w_dec[3:0];
      end
    end
  end

  // A capture on the timeout edge wins: it restarts the timer and keeps its bit.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_shadow    <= 32'h0;
      r_toCnt     <= '0;
      Disp_Data   <= 32'h0;
      Frame_Valid <= 1'b0;
      Digit_Mask  <= 8'h00;
      Seg_Err     <= 1'b0;
      Sel_Err     <= 1'b0;
      Scan_Lost   <= 1'b0;
    end else begin
      Frame_Valid <= w_frameDone;
      Seg_Err     <= w_segErr;
      Sel_Err     <= w_selErr;
      if (w_capture) begin
        r_shadow  <= w_shadowNew;
        r_toCnt   <= '0;
        Scan_Lost <= 1'b0;
        if (w_frameDone) begin
          Disp_Data  <= w_shadowNew;
          Digit_Mask <= 8'h00;
        end else begin
          Digit_Mask <= w_maskNew;
        end
      end else begin
        if (r_toCnt != TO_MAX) begin
          r_toCnt <= r_toCnt + TO_W'(1);
        end
        if (r_toCnt == TO_LAST) begin
          Digit_Mask <= 8'h00;
          Scan_Lost  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hex8_scan_decoder.sv
// Testbench for hex8_scan_decoder: table-driven digit vectors, hand-written
// scan sequences and randomized digits, all compared every cycle against a
// run-length based reference model of the display receiver.
module tb_hex8_scan_decoder;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 1000;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [7:0]  sel = 8'h00;
  logic [7:0]  seg = 8'hFF;
  logic [31:0] dispData;
  logic        frameValid;
  logic [7:0]  digitMask;
  logic        segErr;
  logic        selErr;
  logic        scanLost;

  int nVectors = 0;
  int nMiscompares = 0;

  // Glyph for each hex value, active-low, DP off.
  bit [7:0] segCode [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model state
  logic [31:0] mDisp, mShadow;
  logic [7:0]  mMask, mLastSel, mLastSeg;
  logic        mLost, mFv, mSegE, mSelE;
  int          mIdle, mRun;
  bit          mPending;

  // Pulse counters over a stimulus window, taken from DUT outputs
  int cntFv, cntSegE, cntSelE;

  typedef struct {
    logic [7:0] sel;
    logic [7:0] seg;
    int         dwell;
    int         gap;
    int         expSegErr;
    int         expSelErr;
    logic [7:0] expMask;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  hex8_scan_decoder #(
    .CLOCK_FREQ(50_000_000),
    .SETTLE_CYCLES(SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .Clk(clk),
    .Reset_n(resetN),
    .SEL(sel),
    .SEG(seg),
    .Disp_Data(dispData),
    .Frame_Valid(frameValid),
    .Digit_Mask(digitMask),
    .Seg_Err(segErr),
    .Sel_Err(selErr),
    .Scan_Lost(scanLost)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mDisp = 32'h0; mShadow = 32'h0; mMask = 8'h00; mLost = 1'b0;
    mFv = 1'b0; mSegE = 1'b0; mSelE = 1'b0;
    mIdle = 0; mLastSel = 8'h00; mLastSeg = 8'h00; mRun = 2; mPending = 1'b0;
  endtask

  task automatic modelDecode(input logic [7:0] g, output bit valid, output logic [3:0] nib);
    valid = 1'b0;
    nib = 4'h0;
    for (int k = 0; k < 16; k++) begin
      if (segCode[k] == g && g[7]) begin
        valid = 1'b1;
        nib = 4'(k);
      end
    end
  endtask

  // One clock: advance the model by the rules of the display bus, then compare.
  // A value held for SETTLE+2 consecutive samples is decoded on the next edge.
  task automatic tick();
    bit captured, valid;
    logic [3:0] nib;
    @(posedge clk);
    mFv = 1'b0; mSegE = 1'b0; mSelE = 1'b0; captured = 1'b0;
    if (mPending) begin
      mPending = 1'b0;
      if (mLastSel != 8'h00) begin
        if ($countones(mLastSel) != 1) begin
          mSelE = 1'b1;
        end else begin
          modelDecode(mLastSeg, valid, nib);
          if (!valid) begin
            mSegE = 1'b1;
          end else begin
            for (int i = 0; i < 8; i++)
              if (mLastSel[i]) mShadow[4*i +: 4] = nib;
            mMask = mMask | mLastSel;
            captured = 1'b1;
            if (mMask == 8'hFF) begin
              mDisp = mShadow;
              mFv = 1'b1;
              mMask = 8'h00;
            end
          end
        end
      end
    end
    if (captured) begin
      mIdle = 0;
      mLost = 1'b0;
    end else if (mIdle < TIMEOUT) begin
      mIdle++;
      if (mIdle == TIMEOUT) begin
        mMask = 8'h00;
        mLost = 1'b1;
      end
    end
    if (sel == mLastSel && seg == mLastSeg) begin
      if (mRun < 1000000) mRun++;
    end else begin
      mLastSel = sel;
      mLastSeg = seg;
      mRun = 1;
    end
    if (mRun == SETTLE + 2) mPending = 1'b1;
    #1;
    cntFv   += int'(frameValid);
    cntSegE += int'(segErr);
    cntSelE += int'(selErr);
    checkOutput("Disp_Data", dispData, mDisp);
    checkOutput("Digit_Mask", {24'h0, digitMask}, {24'h0, mMask});
    checkOutput("Frame_Valid", {31'h0, frameValid}, {31'h0, mFv});
    checkOutput("Seg_Err", {31'h0, segErr}, {31'h0, mSegE});
    checkOutput("Sel_Err", {31'h0, selErr}, {31'h0, mSelE});
    checkOutput("Scan_Lost", {31'h0, scanLost}, {31'h0, mLost});
  endtask

  task automatic applyStimulus(input logic [7:0] s, input logic [7:0] g, input int n);
    sel = s;
    seg = g;
    repeat (n) tick();
  endtask

  task automatic scanWord(input logic [31:0] val, input bit reverse, input int dwell);
    int d;
    for (int k = 0; k < 8; k++) begin
      d = reverse ? 7 - k : k;
      applyStimulus(8'(1 << d), segCode[val[4*d +: 4]], dwell);
    end
  endtask

  task automatic clearCounts();
    cntFv = 0; cntSegE = 0; cntSelE = 0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " Disp_Data"}, dispData, 32'h0);
    checkOutput({tag, " Digit_Mask"}, {24'h0, digitMask}, 32'h0);
    checkOutput({tag, " Frame_Valid"}, {31'h0, frameValid}, 32'h0);
    checkOutput({tag, " Seg_Err"}, {31'h0, segErr}, 32'h0);
    checkOutput({tag, " Sel_Err"}, {31'h0, selErr}, 32'h0);
    checkOutput({tag, " Scan_Lost"}, {31'h0, scanLost}, 32'h0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic pulseReset();
    resetN = 1'b0;
    #1;
    checkAllZero("reset");
    modelReset();
    sel = 8'h00;
    seg = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    #3 resetN = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] rs, rg;
    int rsel, rseg, rdw;

    vecs[0]  = '{8'h04, 8'hFF, 50, 2, 1, 0, 8'h00};
    vecs[1]  = '{8'h03, 8'hC0, 50, 2, 0, 1, 8'h00};
    vecs[2]  = '{8'h00, 8'hC0, 50, 2, 0, 0, 8'h00};
    vecs[3]  = '{8'h08, 8'hC0,  3, 0, 0, 0, 8'h00};
    vecs[4]  = '{8'h08, 8'h92, 50, 2, 0, 0, 8'h08};
    vecs[5]  = '{8'h01, 8'h40, 50, 2, 1, 0, 8'h08};
    vecs[6]  = '{8'h01, 8'hF9, 50, 2, 0, 0, 8'h09};
    vecs[7]  = '{8'h01, 8'hA4, 50, 2, 0, 0, 8'h09};
    vecs[8]  = '{8'h10, 8'h8E,  5, 2, 0, 0, 8'h09};
    vecs[9]  = '{8'h20, 8'h86,  6, 2, 0, 0, 8'h29};
    vecs[10] = '{8'h81, 8'hFF, 50, 2, 0, 1, 8'h29};

    // Power-on reset
    modelReset();
    clearCounts();
    repeat (3) @(posedge clk);
    #2;
    checkAllZero("power-on");
    #3 resetN = 1'b1;

    // Full forward scan
    clearCounts();
    scanWord(32'h1234_ABCD, 1'b0, 50);
    checkOutput("scan1 frame count", cntFv, 1);
    checkOutput("scan1 data", dispData, 32'h1234_ABCD);
    checkOutput("scan1 mask", {24'h0, digitMask}, 32'h0);

    // Digit-level vectors: errors, blanks, glitch, recapture, minimum dwell
    for (int v = 0; v < 11; v++) begin
      clearCounts();
      applyStimulus(vecs[v].sel, vecs[v].seg, vecs[v].dwell);
      if (vecs[v].gap > 0) applyStimulus(8'h00, 8'hFF, vecs[v].gap);
      checkOutput($sformatf("vec%0d seg_err count", v), cntSegE, vecs[v].expSegErr);
      checkOutput($sformatf("vec%0d sel_err count", v), cntSelE, vecs[v].expSelErr);
      checkOutput($sformatf("vec%0d mask", v), {24'h0, digitMask}, {24'h0, vecs[v].expMask});
    end

    // Finish the partial frame left by the vectors
    clearCounts();
    applyStimulus(8'h02, segCode[7], 50);
    applyStimulus(8'h04, segCode[9], 50);
    applyStimulus(8'h10, segCode[11], 50);
    applyStimulus(8'h40, segCode[12], 50);
    applyStimulus(8'h80, segCode[15], 50);
    checkOutput("mixed frame count", cntFv, 1);
    checkOutput("mixed frame data", dispData, 32'hFCEB_5972);

    // Timeout: five captures, then a stuck invalid digit
    for (int d = 1; d <= 5; d++) applyStimulus(8'(1 << d), segCode[3], 50);
    checkOutput("pre-timeout mask", {24'h0, digitMask}, 32'h3E);
    clearCounts();
    applyStimulus(8'h01, 8'hFF, 800);
    checkOutput("timeout early lost", {31'h0, scanLost}, 32'h0);
    applyStimulus(8'h01, 8'hFF, 200);
    checkOutput("timeout seg_err count", cntSegE, 1);
    checkOutput("timeout lost", {31'h0, scanLost}, 32'h1);
    checkOutput("timeout mask", {24'h0, digitMask}, 32'h0);
    checkOutput("timeout data held", dispData, 32'hFCEB_5972);
    applyStimulus(8'h01, segCode[0], 50);
    checkOutput("recover lost", {31'h0, scanLost}, 32'h0);
    checkOutput("recover mask", {24'h0, digitMask}, 32'h01);

    // Reset mid-frame, then a clean scan
    for (int d = 0; d < 4; d++) applyStimulus(8'(1 << d), segCode[15 - d], 50);
    checkOutput("partial mask", {24'h0, digitMask}, 32'h0F);
    pulseReset();
    clearCounts();
    scanWord(32'h89AB_CDEF, 1'b0, 50);
    checkOutput("post-reset frame count", cntFv, 1);
    checkOutput("post-reset data", dispData, 32'h89AB_CDEF);

    // All ones forward, all zeros in reverse order
    clearCounts();
    scanWord(32'hFFFF_FFFF, 1'b0, 50);
    checkOutput("ones frame count", cntFv, 1);
    checkOutput("ones data", dispData, 32'hFFFF_FFFF);
    clearCounts();
    scanWord(32'h0000_0000, 1'b1, 50);
    checkOutput("zeros frame count", cntFv, 1);
    checkOutput("zeros data", dispData, 32'h0000_0000);

    // Randomized digits, short and long dwells, occasional bad SEL/SEG
    for (int n = 0; n < 400; n++) begin
      rsel = int'($urandom_range(0, 9));
      rseg = int'($urandom_range(0, 7));
      rdw  = int'($urandom_range(1, 12));
      if (rsel == 0)      rs = 8'h00;
      else if (rsel == 1) rs = 8'($urandom);
      else                rs = 8'(1 << $urandom_range(0, 7));
      if (rseg == 0) rg = 8'($urandom);
      else           rg = segCode[$urandom_range(0, 15)];
      applyStimulus(rs, rg, rdw);
    end
    applyStimulus(8'h00, 8'hFF, 10);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
